tl_rx_err_msg_tx_sched: RTL and testbench
=========================================

Name: tl_rx_err_msg_tx_sched

Overview:
Sequencer that drains the RX error-handling message/completion FIFO toward the TX side. It pops one FIFO entry at a time and optionally issues an ERR_COR/ERR_NONFATAL/ERR_FATAL message TLP, gated by the Device Control reporting enables. It then issues an Unsupported Request completion request when the entry carries one. It owns the FIFO's msg_trans_en and read_ptr_incr strobes and sits between the error-handling FIFO and the TX arbiter.

Parameters:
MSG_WIDTH, 128, width of message TLP header from FIFO / to TX
REQ_WIDTH, 16, requester ID width
TAG_WIDTH, 8, tag width
CNT_WIDTH, 8, width of saturating statistics counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
empty_flag  input  1  FIFO empty indication
tlp_msg  input  MSG_WIDTH  FIFO head message header, valid only while msg_trans_en=1
ur_cpl_valid  input  1  FIFO head needs UR completion, valid only while msg_trans_en=1
cor_err_rpt_en  input  1  Device Control: correctable reporting enable
nonfatal_err_rpt_en  input  1  Device Control: non-fatal reporting enable
fatal_err_rpt_en  input  1  Device Control: fatal reporting enable
tx_msg_ready  input  1  TX accepts message
tx_cpl_ready  input  1  TX accepts UR completion request
msg_trans_en  output  1  enables FIFO head output
read_ptr_incr  output  1  pops FIFO head
tx_msg_valid  output  1  message request to TX
tx_msg  output  MSG_WIDTH  message header to TX
tx_cpl_valid  output  1  UR completion request to TX
tx_cpl_req_id  output  REQ_WIDTH  completer target requester ID
tx_cpl_tag  output  TAG_WIDTH  completion tag
busy  output  1  state != IDLE
msg_sent_cnt  output  CNT_WIDTH  messages accepted by TX
msg_suppressed_cnt  output  CNT_WIDTH  entries whose message was dropped

Behaviour:
- Reset: state=IDLE; all outputs 0; holding registers 0. Reset mid-operation aborts the current entry. FIFO pointers reset independently, so no pop is issued.
- Control outputs (msg_trans_en, read_ptr_incr, tx_msg_valid, tx_cpl_valid, busy) decode from the state register only. There is no combinational input-to-output path.
- Field extraction from the captured header: msg_code = tlp_msg[71:64]; req_id = tlp_msg[95:80]; tag = tlp_msg[79:72] (defaults shown).
- IDLE: if empty_flag=0, go to FETCH.
- FETCH (1 cycle): msg_trans_en=1. At the clock edge, capture tlp_msg into tx_msg, req_id/tag into tx_cpl_*, ur_cpl_valid into cpl_pend, and compute rpt:
  - 0x30 with cor_err_rpt_en
  - 0x31 with nonfatal_err_rpt_en
  - 0x33 with fatal_err_rpt_en
  - any other code gives rpt=0.
- FETCH next state: rpt=1 goes to MSG. Otherwise increment msg_suppressed_cnt only if msg_code!=0, then go to CPL if cpl_pend, else POP.
- MSG: tx_msg_valid=1. tx_msg is held stable until tx_msg_ready=1. On acceptance, increment msg_sent_cnt and go to CPL if cpl_pend, else POP.
- CPL: tx_cpl_valid=1. tx_cpl_req_id/tag are held stable until tx_cpl_ready=1, then go to POP. Message is always issued before completion.
- POP (1 cycle): read_ptr_incr=1, then go to IDLE. Exactly one pop per entry; a pop is never issued while empty_flag=1 is sampled in IDLE.
- Enables are sampled only in FETCH. Changes during MSG/CPL do not retract a request.
- Ready asserted while the corresponding valid is low is ignored.
- Counters saturate at all-ones; no wrap.
- Entry with msg_code=0 and cpl_pend=0 goes FETCH→POP (silent discard, no counter change).
- Latency (readies high): empty_flag falls at cycle 0, FETCH at 1, tx_msg_valid at 2, tx_cpl_valid at 3, read_ptr_incr at 4, IDLE at 5. Message-only entry takes 4 cycles per entry.
- Back-to-back entries: IDLE re-checks empty_flag after the pop has updated the pointers, so the last entry is never double-popped.

Test Plan:
- Single fatal entry (code 0x33, ur_cpl_valid=0), fatal_err_rpt_en=1, readies high → tx_msg_valid 1 cycle with tx_msg=FIFO header, read_ptr_incr pulse at cycle 3, msg_sent_cnt=1.
- Non-fatal entry with ur_cpl_valid=1, req_id=0xABCD, tag=0x5A, tx_msg_ready delayed 3 cycles → tx_msg held stable 4 cycles, then tx_cpl_valid with req_id 0xABCD and tag 0x5A, exactly one pop.
- Correctable entry with cor_err_rpt_en=0 and ur_cpl_valid=1 → no tx_msg_valid, tx_cpl_valid asserted, msg_suppressed_cnt=1, one pop.
- Three queued entries with readies high → three pops, no pop while empty, and busy drops after the third POP.
- Reset asserted during CPL with tx_cpl_ready low → all outputs 0 asynchronously, state IDLE, counters 0.
- 300 reportable entries with CNT_WIDTH=8 → msg_sent_cnt saturates at 255.

Source files
------------

// File: rtl/tl_rx_err_msg_tx_sched.sv
// Drains the RX error-handling FIFO toward TX: fetches one entry, optionally issues
// an ERR_COR/ERR_NONFATAL/ERR_FATAL message, then an optional UR completion, then pops.
module tl_rx_err_msg_tx_sched #(
    parameter int MSG_WIDTH = 128,
    parameter int REQ_WIDTH = 16,
    parameter int TAG_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty_flag,
    input  logic [MSG_WIDTH-1:0] tlp_msg,
    input  logic                 ur_cpl_valid,
    input  logic                 cor_err_rpt_en,
    input  logic                 nonfatal_err_rpt_en,
    input  logic                 fatal_err_rpt_en,
    input  logic                 tx_msg_ready,
    input  logic                 tx_cpl_ready,
    output logic                 msg_trans_en,
    output logic                 read_ptr_incr,
    output logic                 tx_msg_valid,
    output logic [MSG_WIDTH-1:0] tx_msg,
    output logic                 tx_cpl_valid,
    output logic [REQ_WIDTH-1:0] tx_cpl_req_id,
    output logic [TAG_WIDTH-1:0] tx_cpl_tag,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] msg_sent_cnt,
    output logic [CNT_WIDTH-1:0] msg_suppressed_cnt
);

    localparam int CODE_LSB = 64;
    localparam int TAG_LSB  = 72;
    localparam int REQ_LSB  = 80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MSG   = 3'd2,
        ST_CPL   = 3'd3,
        ST_POP   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   cpl_pend_r;
    logic [7:0]             msg_code_s;
    logic                   rpt_s;
    logic                   sent_inc_s;
    logic                   supp_inc_s;
    logic                   msg_trans_en_r;
    logic                   read_ptr_incr_r;
    logic                   tx_msg_valid_r;
    logic                   tx_cpl_valid_r;
    logic                   busy_r;
    logic [MSG_WIDTH-1:0]   tx_msg_r;
    logic [REQ_WIDTH-1:0]   tx_cpl_req_id_r;
    logic [TAG_WIDTH-1:0]   tx_cpl_tag_r;
    logic [CNT_WIDTH-1:0]   msg_sent_cnt_r;
    logic [CNT_WIDTH-1:0]   msg_suppressed_cnt_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decode the head message code against the Device Control reporting enables.
    always_comb begin
        msg_code_s = tlp_msg[CODE_LSB +: 8];
        case (msg_code_s)
            8'h30:   rpt_s = cor_err_rpt_en;
            8'h31:   rpt_s = nonfatal_err_rpt_en;
            8'h33:   rpt_s = fatal_err_rpt_en;
            default: rpt_s = 1'b0;
        endcase
    end

    // Next-state and counter-increment decode.
    always_comb begin
        state_s    = state_r;
        sent_inc_s = 1'b0;
        supp_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_flag) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (rpt_s) begin
                    state_s = ST_MSG;
                end else begin
                    supp_inc_s = (msg_code_s != 8'h00);
                    state_s    = ur_cpl_valid ? ST_CPL : ST_POP;
                end
            end
            ST_MSG: begin
                if (tx_msg_ready) begin
                    sent_inc_s = 1'b1;
                    state_s    = cpl_pend_r ? ST_CPL : ST_POP;
                end else begin
                    state_s = ST_MSG;
                end
            end
            ST_CPL: begin
                if (tx_cpl_ready) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_CPL;
                end
            end
            ST_POP:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus control strobes registered from the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            msg_trans_en_r  <= 1'b0;
            read_ptr_incr_r <= 1'b0;
            tx_msg_valid_r  <= 1'b0;
            tx_cpl_valid_r  <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            msg_trans_en_r  <= (state_s == ST_FETCH);
            read_ptr_incr_r <= (state_s == ST_POP);
            tx_msg_valid_r  <= (state_s == ST_MSG);
            tx_cpl_valid_r  <= (state_s == ST_CPL);
            busy_r          <= (state_s != ST_IDLE);
        end
    end

    // Capture the head entry in FETCH; held untouched until the next entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_msg_r        <= {MSG_WIDTH{1'b0}};
            tx_cpl_req_id_r <= {REQ_WIDTH{1'b0}};
            tx_cpl_tag_r    <= {TAG_WIDTH{1'b0}};
            cpl_pend_r      <= 1'b0;
        end else if (state_r == ST_FETCH) begin
            tx_msg_r        <= tlp_msg;
            tx_cpl_req_id_r <= tlp_msg[REQ_LSB +: REQ_WIDTH];
            tx_cpl_tag_r    <= tlp_msg[TAG_LSB +: TAG_WIDTH];
            cpl_pend_r      <= ur_cpl_valid;
        end else begin
            tx_msg_r        <= tx_msg_r;
            tx_cpl_req_id_r <= tx_cpl_req_id_r;
            tx_cpl_tag_r    <= tx_cpl_tag_r;
            cpl_pend_r      <= cpl_pend_r;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_sent_cnt_r       <= {CNT_WIDTH{1'b0}};
            msg_suppressed_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (sent_inc_s) begin
                msg_sent_cnt_r <= sat_inc(msg_sent_cnt_r);
            end else begin
                msg_sent_cnt_r <= msg_sent_cnt_r;
            end
            if (supp_inc_s) begin
                msg_suppressed_cnt_r <= sat_inc(msg_suppressed_cnt_r);
            end else begin
                msg_suppressed_cnt_r <= msg_suppressed_cnt_r;
            end
        end
    end

    assign msg_trans_en       = msg_trans_en_r;
    assign read_ptr_incr      = read_ptr_incr_r;
    assign tx_msg_valid       = tx_msg_valid_r;
    assign tx_cpl_valid       = tx_cpl_valid_r;
    assign busy               = busy_r;
    assign tx_msg             = tx_msg_r;
    assign tx_cpl_req_id      = tx_cpl_req_id_r;
    assign tx_cpl_tag         = tx_cpl_tag_r;
    assign msg_sent_cnt       = msg_sent_cnt_r;
    assign msg_suppressed_cnt = msg_suppressed_cnt_r;

endmodule

// File: tb/tb_tl_rx_err_msg_tx_sched.sv
// Bench for tl_rx_err_msg_tx_sched: FIFO model plus per-entry expected event list
// (message, completion, pop), directed literal checks and a randomized phase.
module tb_tl_rx_err_msg_tx_sched;
    localparam int MW   = 128;
    localparam int RW   = 16;
    localparam int TW   = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [1:0] K_MSG = 2'd0;
    localparam logic [1:0] K_CPL = 2'd1;
    localparam logic [1:0] K_POP = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [MW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          empty_flag = 1'b1;
    logic [MW-1:0] tlp_msg = '0;
    logic          ur_cpl_valid = 1'b0;
    logic          cor_err_rpt_en = 1'b0;
    logic          nonfatal_err_rpt_en = 1'b0;
    logic          fatal_err_rpt_en = 1'b0;
    logic          tx_msg_ready = 1'b0;
    logic          tx_cpl_ready = 1'b0;
    logic          msg_trans_en, read_ptr_incr, tx_msg_valid, tx_cpl_valid, busy;
    logic [MW-1:0] tx_msg;
    logic [RW-1:0] tx_cpl_req_id;
    logic [TW-1:0] tx_cpl_tag;
    logic [CW-1:0] msg_sent_cnt, msg_suppressed_cnt;

    tl_rx_err_msg_tx_sched #(.MSG_WIDTH(MW), .REQ_WIDTH(RW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .empty_flag(empty_flag), .tlp_msg(tlp_msg),
        .ur_cpl_valid(ur_cpl_valid), .cor_err_rpt_en(cor_err_rpt_en),
        .nonfatal_err_rpt_en(nonfatal_err_rpt_en), .fatal_err_rpt_en(fatal_err_rpt_en),
        .tx_msg_ready(tx_msg_ready), .tx_cpl_ready(tx_cpl_ready),
        .msg_trans_en(msg_trans_en), .read_ptr_incr(read_ptr_incr),
        .tx_msg_valid(tx_msg_valid), .tx_msg(tx_msg), .tx_cpl_valid(tx_cpl_valid),
        .tx_cpl_req_id(tx_cpl_req_id), .tx_cpl_tag(tx_cpl_tag), .busy(busy),
        .msg_sent_cnt(msg_sent_cnt), .msg_suppressed_cnt(msg_suppressed_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [MW:0] fifo[$];
    ev_t         evq[$];
    int          m_sent = 0, m_supp = 0;
    int          cyc = 0, ne_cyc = 0, msg_acc_cyc = 0, pop_cyc = 0;
    int          msg_v_cyc = 0, cpl_cnt = 0, pop_cnt = 0, wd = 0;
    logic [MW-1:0] last_msg = '0;
    logic [23:0]   last_cpl = '0;
    bit          rand_mode = 1'b0;
    logic        cfg_cor = 1'b1, cfg_nf = 1'b1, cfg_fat = 1'b1;
    logic        cfg_rdy_msg = 1'b1, cfg_rdy_cpl = 1'b1;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [MW:0] make_entry(input logic [7:0] code, input logic ur,
                                               input logic [15:0] req, input logic [7:0] tag);
        logic [MW-1:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[71:64] = code;
        h[79:72] = tag;
        h[95:80] = req;
        return {ur, h};
    endfunction

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 4))
            0:       return 8'h30;
            1:       return 8'h31;
            2:       return 8'h33;
            3:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor/driver: checks outputs against the entry model every cycle, then drives inputs.
    always @(negedge clk) begin : mon
        logic [MW:0]   ent;
        logic [MW-1:0] hdr;
        logic [7:0]    code;
        logic          rpt;
        logic          was_empty;
        if (!rst) begin
            fifo.delete();
            evq.delete();
            m_sent = 0;
            m_supp = 0;
            wd = 0;
            empty_flag = 1'b1;
            tx_msg_ready = 1'b0;
            tx_cpl_ready = 1'b0;
        end else begin
            cyc++;
            chk("sent_cnt", MW'(msg_sent_cnt), MW'(m_sent));
            chk("supp_cnt", MW'(msg_suppressed_cnt), MW'(m_supp));
            chk("busy", MW'(busy), MW'(msg_trans_en || evq.size() != 0));
            chk("strobe_excl", MW'($countones({msg_trans_en, read_ptr_incr, tx_msg_valid, tx_cpl_valid}) > 1), '0);
            if (rand_mode) begin
                cor_err_rpt_en      = ($urandom_range(0, 3) != 0);
                nonfatal_err_rpt_en = ($urandom_range(0, 3) != 0);
                fatal_err_rpt_en    = ($urandom_range(0, 3) != 0);
                tx_msg_ready        = ($urandom_range(0, 2) != 0);
                tx_cpl_ready        = ($urandom_range(0, 2) != 0);
            end else begin
                cor_err_rpt_en      = cfg_cor;
                nonfatal_err_rpt_en = cfg_nf;
                fatal_err_rpt_en    = cfg_fat;
                tx_msg_ready        = cfg_rdy_msg;
                tx_cpl_ready        = cfg_rdy_cpl;
            end
            tlp_msg      = {$urandom, $urandom, $urandom, $urandom};
            ur_cpl_valid = 1'($urandom);
            if (msg_trans_en) begin
                chk("fetch_nonempty", MW'(fifo.size() != 0), MW'(1));
                chk("fetch_prev_done", MW'(evq.size()), '0);
                if (fifo.size() != 0) begin
                    ent = fifo[0];
                    hdr = ent[MW-1:0];
                    tlp_msg = hdr;
                    ur_cpl_valid = ent[MW];
                    code = hdr[71:64];
                    case (code)
                        8'h30:   rpt = cor_err_rpt_en;
                        8'h31:   rpt = nonfatal_err_rpt_en;
                        8'h33:   rpt = fatal_err_rpt_en;
                        default: rpt = 1'b0;
                    endcase
                    if (rpt) evq.push_back('{kind: K_MSG, data: hdr});
                    else if (code != 8'h00 && m_supp < CMAX) m_supp++;
                    if (ent[MW]) evq.push_back('{kind: K_CPL, data: MW'({hdr[95:80], hdr[79:72]})});
                    evq.push_back('{kind: K_POP, data: '0});
                end
            end
            if (tx_msg_valid) begin
                msg_v_cyc++;
                if (tx_msg_ready) begin
                    if (evq.size() == 0) chk("msg_unexpected", MW'(1), '0);
                    else begin
                        chk("msg_kind", MW'(evq[0].kind), MW'(K_MSG));
                        chk("msg_data", tx_msg, evq[0].data);
                        void'(evq.pop_front());
                    end
                    if (m_sent < CMAX) m_sent++;
                    last_msg = tx_msg;
                    msg_acc_cyc = cyc;
                end else if (evq.size() != 0) begin
                    chk("msg_hold", tx_msg, evq[0].data);
                end
            end
            if (tx_cpl_valid) begin
                if (evq.size() == 0) chk("cpl_unexpected", MW'(1), '0);
                else begin
                    chk("cpl_kind", MW'(evq[0].kind), MW'(K_CPL));
                    chk("cpl_data", MW'({tx_cpl_req_id, tx_cpl_tag}), evq[0].data);
                    if (tx_cpl_ready) void'(evq.pop_front());
                end
                if (tx_cpl_ready) begin
                    cpl_cnt++;
                    last_cpl = {tx_cpl_req_id, tx_cpl_tag};
                end
            end
            if (read_ptr_incr) begin
                if (evq.size() == 0) chk("pop_unexpected", MW'(1), '0);
                else begin
                    chk("pop_kind", MW'(evq[0].kind), MW'(K_POP));
                    void'(evq.pop_front());
                end
                chk("pop_nonempty", MW'(fifo.size() != 0), MW'(1));
                if (fifo.size() != 0) void'(fifo.pop_front());
                pop_cnt++;
                pop_cyc = cyc;
                wd = 0;
            end
            if (rand_mode && $urandom_range(0, 5) == 0 && fifo.size() < 8)
                fifo.push_back(make_entry(rand_code(), 1'($urandom), 16'($urandom), 8'($urandom)));
            was_empty = empty_flag;
            empty_flag = (fifo.size() == 0);
            if (was_empty && !empty_flag) ne_cyc = cyc;
            if (fifo.size() != 0) wd++;
            if (wd > 100) begin
                chk("watchdog", MW'(1), '0);
                wd = 0;
            end
        end
    end

    task automatic push(input logic [7:0] code, input logic ur, input logic [15:0] req,
                        input logic [7:0] tag, output logic [MW-1:0] hdr);
        logic [MW:0] e;
        e = make_entry(code, ur, req, tag);
        hdr = e[MW-1:0];
        fifo.push_back(e);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (fifo.size() == 0 && !busy && evq.size() == 0) break;
        end
        if (n == budget) chk({nm, "_timeout"}, MW'(1), '0);
    endtask

    task automatic wait_sig(input string nm, input int which);
        int n;
        for (n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (which == 0 && tx_msg_valid) break;
            if (which == 1 && tx_cpl_valid) break;
        end
        if (n == 20) chk({nm, "_timeout"}, MW'(1), '0);
    endtask

    initial begin
        logic [MW-1:0] h;
        int b_msg, b_cpl, b_pop;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", MW'({msg_trans_en, read_ptr_incr, tx_msg_valid, tx_cpl_valid, busy}), '0);
        chk("reset_data", tx_msg | MW'({tx_cpl_req_id, tx_cpl_tag, msg_sent_cnt, msg_suppressed_cnt}), '0);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single fatal entry, readies high
        b_msg = msg_v_cyc;
        push(8'h33, 1'b0, 16'h1111, 8'h22, h);
        wait_idle("A", 30);
        chk("A_msg_lat", MW'(msg_acc_cyc - ne_cyc), MW'(2));
        chk("A_pop_lat", MW'(pop_cyc - ne_cyc), MW'(3));
        chk("A_msg_cycles", MW'(msg_v_cyc - b_msg), MW'(1));
        chk("A_sent", MW'(msg_sent_cnt), MW'(1));
        chk("A_hdr", last_msg, h);

        // Non-fatal with UR completion, message ready delayed
        b_msg = msg_v_cyc; b_cpl = cpl_cnt; b_pop = pop_cnt;
        cfg_rdy_msg = 1'b0;
        push(8'h31, 1'b1, 16'hABCD, 8'h5A, h);
        wait_sig("B_msg", 0);
        repeat (3) @(posedge clk);
        #1 cfg_rdy_msg = 1'b1;
        wait_idle("B", 30);
        chk("B_msg_cycles", MW'(msg_v_cyc - b_msg), MW'(4));
        chk("B_hdr", last_msg, h);
        chk("B_cpl", MW'(last_cpl), MW'(24'hABCD5A));
        chk("B_cpls", MW'(cpl_cnt - b_cpl), MW'(1));
        chk("B_pops", MW'(pop_cnt - b_pop), MW'(1));

        // Correctable with reporting disabled, UR completion still issued
        b_msg = msg_v_cyc; b_cpl = cpl_cnt; b_pop = pop_cnt;
        cfg_cor = 1'b0;
        push(8'h30, 1'b1, 16'h0102, 8'h03, h);
        wait_idle("C", 30);
        cfg_cor = 1'b1;
        chk("C_msg_cycles", MW'(msg_v_cyc - b_msg), '0);
        chk("C_cpls", MW'(cpl_cnt - b_cpl), MW'(1));
        chk("C_supp", MW'(msg_suppressed_cnt), MW'(1));
        chk("C_pops", MW'(pop_cnt - b_pop), MW'(1));

        // Three queued entries, including a silent discard
        b_cpl = cpl_cnt; b_pop = pop_cnt;
        push(8'h33, 1'b0, 16'h0001, 8'h01, h);
        push(8'h00, 1'b0, 16'h0002, 8'h02, h);
        push(8'h31, 1'b1, 16'h0003, 8'h03, h);
        wait_idle("D", 60);
        chk("D_pops", MW'(pop_cnt - b_pop), MW'(3));
        chk("D_cpls", MW'(cpl_cnt - b_cpl), MW'(1));
        chk("D_sent", MW'(msg_sent_cnt), MW'(4));
        chk("D_supp", MW'(msg_suppressed_cnt), MW'(1));
        chk("D_busy", MW'(busy), '0);

        // 300 reportable entries saturate the sent counter
        for (int i = 0; i < 300; i++) push(8'h30, 1'b0, 16'($urandom), 8'($urandom), h);
        wait_idle("F", 1600);
        chk("F_sat", MW'(msg_sent_cnt), MW'(255));

        // Reset in the middle of a stalled completion
        cfg_rdy_cpl = 1'b0;
        push(8'h33, 1'b1, 16'h5555, 8'h66, h);
        wait_sig("E_cpl", 1);
        #2 rst = 1'b0;
        #1;
        chk("E_ctrl", MW'({msg_trans_en, read_ptr_incr, tx_msg_valid, tx_cpl_valid, busy}), '0);
        chk("E_data", tx_msg | MW'({tx_cpl_req_id, tx_cpl_tag}), '0);
        chk("E_cnts", MW'({msg_sent_cnt, msg_suppressed_cnt}), '0);
        cfg_rdy_cpl = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("E_idle", MW'(busy), '0);

        // Randomized traffic, then drain
        rand_mode = 1'b1;
        repeat (2500) @(posedge clk);
        #1 rand_mode = 1'b0;
        wait_idle("R", 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
